// File: rtl/tx_dsc_fetch_manager.sv
// TX descriptor fetch manager.
// Keeps per-queue head/tail pointers for the TX descriptor rings. Software
// moves the tails. This block round-robins over the enabled, non-empty
// queues and issues one DMA read request per contiguous descriptor burst.
// It advances each head when the DMA engine accepts the request.
module tx_dsc_fetch_manager #(
  parameter int NB_QUEUES = 16,
  parameter int MAX_BURST = 8,
  parameter int RB_AWIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  input  logic [$clog2(NB_QUEUES)-1:0]   cfg_queue_id,
  input  logic                           cfg_enable,
  input  logic [63:0]                    cfg_base_addr,
  input  logic                           in_tail_valid,
  input  logic [$clog2(NB_QUEUES)-1:0]   in_tail_queue_id,
  input  logic [RB_AWIDTH:0]             in_tail,
  output logic                           in_tail_ready,
  output logic                           out_req_valid,
  input  logic                           out_req_ready,
  output logic [$clog2(NB_QUEUES)-1:0]   out_req_queue_id,
  output logic [63:0]                    out_req_addr,
  output logic [$clog2(MAX_BURST):0]     out_req_nb_dsc,
  output logic [RB_AWIDTH:0]             out_req_new_head,
  input  logic [RB_AWIDTH:0]             rb_size,
  output logic [31:0]                    req_cnt,
  output logic [31:0]                    bad_tail_cnt
);

  localparam int QW  = $clog2(NB_QUEUES);
  localparam int PW  = RB_AWIDTH + 1;
  localparam int NBW = $clog2(MAX_BURST) + 1;

  localparam logic [PW-1:0]  MB_PW  = PW'(MAX_BURST);
  localparam logic [NBW-1:0] MB_NB  = NBW'(MAX_BURST);
  localparam logic [PW-1:0]  ONE_PW = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0]  ONE_QW = {{(QW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    SCAN  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Per-queue state
  logic          enable_r [NB_QUEUES];
  logic [63:0]   base_r   [NB_QUEUES];
  logic [PW-1:0] head_r   [NB_QUEUES];
  logic [PW-1:0] tail_r   [NB_QUEUES];

  // Scheduler / request state
  state_t         state_r;
  logic [QW-1:0]  rr_r;
  logic [QW-1:0]  lat_q_r;
  logic           valid_r;
  logic [63:0]    addr_r;
  logic [NBW-1:0] nb_r;
  logic [PW-1:0]  new_head_r;
  logic           discard_r;
  logic [31:0]    req_cnt_r;
  logic [31:0]    bad_tail_cnt_r;
  logic           tail_ready_r;

  // Evaluation of the queue under the round-robin pointer
  logic [PW-1:0]  mask_s;
  logic [PW-1:0]  cur_head_s;
  logic [PW-1:0]  cur_tail_s;
  logic [PW-1:0]  pending_s;
  logic [PW-1:0]  contig_s;
  logic [NBW-1:0] pend_nb_s;
  logic [NBW-1:0] contig_nb_s;
  logic [NBW-1:0] nb_s;
  logic [PW-1:0]  new_head_s;
  logic [63:0]    addr_s;
  logic           eligible_s;
  logic           hs_s;
  logic           tail_bad_s;
  logic           cfg_hits_rr_s;
  logic           cfg_hits_lat_s;

  assign mask_s      = rb_size - ONE_PW;
  assign cur_head_s  = head_r[rr_r];
  assign cur_tail_s  = tail_r[rr_r];
  assign pending_s   = (cur_tail_s - cur_head_s) & mask_s;
  assign contig_s    = rb_size - cur_head_s;
  // Clamp each bound to MAX_BURST first so the minimum fits the count width
  assign pend_nb_s   = (pending_s >= MB_PW) ? MB_NB : pending_s[NBW-1:0];
  assign contig_nb_s = (contig_s >= MB_PW) ? MB_NB : contig_s[NBW-1:0];
  assign nb_s        = (contig_nb_s < pend_nb_s) ? contig_nb_s : pend_nb_s;
  assign new_head_s  = (cur_head_s + {{(PW-NBW){1'b0}}, nb_s}) & mask_s;
  assign addr_s      = base_r[rr_r] + {{(64-PW-6){1'b0}}, cur_head_s, 6'b000000};
  assign eligible_s  = enable_r[rr_r] && (pending_s != {PW{1'b0}});

  assign hs_s           = valid_r && out_req_ready;
  assign tail_bad_s     = (in_tail >= rb_size);
  assign cfg_hits_rr_s  = cfg_valid && (cfg_queue_id == rr_r);
  assign cfg_hits_lat_s = cfg_valid && (cfg_queue_id == lat_q_r);

  // Per-queue config, tail capture and head advance; a cfg write overrides both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB_QUEUES; i++) begin
        enable_r[i] <= 1'b0;
        base_r[i]   <= 64'd0;
        head_r[i]   <= {PW{1'b0}};
        tail_r[i]   <= {PW{1'b0}};
      end
    end else begin
      if (hs_s && !discard_r) begin
        head_r[lat_q_r] <= new_head_r;
      end
      if (in_tail_valid && !tail_bad_s) begin
        tail_r[in_tail_queue_id] <= in_tail;
      end
      if (cfg_valid) begin
        enable_r[cfg_queue_id] <= cfg_enable;
        base_r[cfg_queue_id]   <= cfg_base_addr;
        head_r[cfg_queue_id]   <= {PW{1'b0}};
        tail_r[cfg_queue_id]   <= {PW{1'b0}};
      end
    end
  end

  // Round-robin scan / issue FSM with registered request fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= SCAN;
      rr_r       <= {QW{1'b0}};
      lat_q_r    <= {QW{1'b0}};
      valid_r    <= 1'b0;
      addr_r     <= 64'd0;
      nb_r       <= {NBW{1'b0}};
      new_head_r <= {PW{1'b0}};
      discard_r  <= 1'b0;
    end else begin
      case (state_r)
        SCAN: begin
          if (eligible_s) begin
            lat_q_r    <= rr_r;
            addr_r     <= addr_s;
            nb_r       <= nb_s;
            new_head_r <= new_head_s;
            valid_r    <= 1'b1;
            // A cfg write landing now already invalidates this snapshot
            discard_r  <= cfg_hits_rr_s;
            state_r    <= ISSUE;
          end else begin
            rr_r <= rr_r + ONE_QW;
          end
        end
        ISSUE: begin
          if (cfg_hits_lat_s) begin
            discard_r <= 1'b1;
          end
          if (hs_s) begin
            valid_r <= 1'b0;
            rr_r    <= lat_q_r + ONE_QW;
            state_r <= SCAN;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= SCAN;
        end
      endcase
    end
  end

  // Statistics counters (free-running, wrap at 2^32) and tail-ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt_r      <= 32'd0;
      bad_tail_cnt_r <= 32'd0;
      tail_ready_r   <= 1'b0;
    end else begin
      tail_ready_r <= 1'b1;
      if (hs_s) begin
        req_cnt_r <= req_cnt_r + 32'd1;
      end
      if (in_tail_valid && tail_bad_s) begin
        bad_tail_cnt_r <= bad_tail_cnt_r + 32'd1;
      end
    end
  end

  assign in_tail_ready    = tail_ready_r;
  assign out_req_valid    = valid_r;
  assign out_req_queue_id = lat_q_r;
  assign out_req_addr     = addr_r;
  assign out_req_nb_dsc   = nb_r;
  assign out_req_new_head = new_head_r;
  assign req_cnt          = req_cnt_r;
  assign bad_tail_cnt     = bad_tail_cnt_r;

endmodule

// File: tb/tb_tx_dsc_fetch_manager.sv
// Directed self-checking bench for tx_dsc_fetch_manager (16 queues, burst 8, ring 1024).
module tb_tx_dsc_fetch_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [3:0]  cfg_queue_id;
  logic        cfg_enable;
  logic [63:0] cfg_base_addr;
  logic        in_tail_valid;
  logic [3:0]  in_tail_queue_id;
  logic [10:0] in_tail;
  logic        in_tail_ready;
  logic        out_req_valid;
  logic        out_req_ready;
  logic [3:0]  out_req_queue_id;
  logic [63:0] out_req_addr;
  logic [3:0]  out_req_nb_dsc;
  logic [10:0] out_req_new_head;
  logic [10:0] rb_size;
  logic [31:0] req_cnt;
  logic [31:0] bad_tail_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_dsc_fetch_manager #(
    .NB_QUEUES(16),
    .MAX_BURST(8),
    .RB_AWIDTH(10)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_queue_id     (cfg_queue_id),
    .cfg_enable       (cfg_enable),
    .cfg_base_addr    (cfg_base_addr),
    .in_tail_valid    (in_tail_valid),
    .in_tail_queue_id (in_tail_queue_id),
    .in_tail          (in_tail),
    .in_tail_ready    (in_tail_ready),
    .out_req_valid    (out_req_valid),
    .out_req_ready    (out_req_ready),
    .out_req_queue_id (out_req_queue_id),
    .out_req_addr     (out_req_addr),
    .out_req_nb_dsc   (out_req_nb_dsc),
    .out_req_new_head (out_req_new_head),
    .rb_size          (rb_size),
    .req_cnt          (req_cnt),
    .bad_tail_cnt     (bad_tail_cnt)
  );

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_queue_id = 4'd0; cfg_enable = 1'b0; cfg_base_addr = 64'd0;
    in_tail_valid = 1'b0; in_tail_queue_id = 4'd0; in_tail = 11'd0;
    out_req_ready = 1'b0;
    rb_size = 11'd1024;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [3:0] q, input logic en, input logic [63:0] base);
    cfg_valid = 1'b1; cfg_queue_id = q; cfg_enable = en; cfg_base_addr = base;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic tail_write(input logic [3:0] q, input logic [10:0] t);
    in_tail_valid = 1'b1; in_tail_queue_id = q; in_tail = t;
    @(posedge clk); #1;
    in_tail_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_req_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic accept();
    out_req_ready = 1'b1;
    @(posedge clk); #1;
    out_req_ready = 1'b0;
  endtask

  task automatic count_valid(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (out_req_valid) hits++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (out_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_req_valid); end
    checks++;
    if (req_cnt !== 32'd0 || bad_tail_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", req_cnt, bad_tail_cnt);
    end
    checks++;
    if (in_tail_ready !== 1'b1) begin failures++; $display("FAIL reset_tail_ready got=%b exp=1", in_tail_ready); end
  endtask

  task automatic test_single();
    int hits;
    do_reset();
    cfg_write(4'd3, 1'b1, 64'h1000_0000);
    tail_write(4'd3, 11'd5);
    checks++;
    if (out_req_valid !== 1'b0) begin failures++; $display("FAIL single_latency got=%b exp=0", out_req_valid); end
    wait_valid();
    checks++;
    if (out_req_valid !== 1'b1 || out_req_queue_id !== 4'd3 || out_req_addr !== 64'h1000_0000 ||
        out_req_nb_dsc !== 4'd5 || out_req_new_head !== 11'd5) begin
      failures++;
      $display("FAIL single_req got v=%b q=%0d a=%h nb=%0d nh=%0d exp v=1 q=3 a=10000000 nb=5 nh=5",
               out_req_valid, out_req_queue_id, out_req_addr, out_req_nb_dsc, out_req_new_head);
    end
    accept();
    checks++;
    if (req_cnt !== 32'd1) begin failures++; $display("FAIL single_req_cnt got=%0d exp=1", req_cnt); end
    count_valid(30, hits);
    checks++;
    if (hits !== 0) begin failures++; $display("FAIL single_drained got=%0d exp=0", hits); end
  endtask

  task automatic test_burst_split();
    logic [63:0] exp_addr [3];
    logic [3:0]  exp_nb   [3];
    logic [10:0] exp_nh   [3];
    exp_addr[0] = 64'h2000_0000; exp_nb[0] = 4'd8; exp_nh[0] = 11'd8;
    exp_addr[1] = 64'h2000_0200; exp_nb[1] = 4'd8; exp_nh[1] = 11'd16;
    exp_addr[2] = 64'h2000_0400; exp_nb[2] = 4'd4; exp_nh[2] = 11'd20;
    do_reset();
    cfg_write(4'd0, 1'b1, 64'h2000_0000);
    tail_write(4'd0, 11'd20);
    for (int i = 0; i < 3; i++) begin
      wait_valid();
      checks++;
      if (out_req_valid !== 1'b1 || out_req_queue_id !== 4'd0 || out_req_addr !== exp_addr[i] ||
          out_req_nb_dsc !== exp_nb[i] || out_req_new_head !== exp_nh[i]) begin
        failures++;
        $display("FAIL burst_req%0d got v=%b q=%0d a=%h nb=%0d nh=%0d exp q=0 a=%h nb=%0d nh=%0d", i,
                 out_req_valid, out_req_queue_id, out_req_addr, out_req_nb_dsc, out_req_new_head,
                 exp_addr[i], exp_nb[i], exp_nh[i]);
      end
      accept();
    end
    checks++;
    if (req_cnt !== 32'd3) begin failures++; $display("FAIL burst_req_cnt got=%0d exp=3", req_cnt); end
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    cfg_write(4'd1, 1'b1, 64'h3000_0000);
    tail_write(4'd1, 11'd1020);
    out_req_ready = 1'b1;
    while (req_cnt != 32'd128 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    out_req_ready = 1'b0;
    checks++;
    if (req_cnt !== 32'd128 || out_req_valid !== 1'b0) begin
      failures++; $display("FAIL wrap_drain got cnt=%0d v=%b exp cnt=128 v=0", req_cnt, out_req_valid);
    end
    tail_write(4'd1, 11'd4);
    wait_valid();
    checks++;
    if (out_req_valid !== 1'b1 || out_req_addr !== 64'h3000_FF00 || out_req_nb_dsc !== 4'd4 ||
        out_req_new_head !== 11'd0) begin
      failures++;
      $display("FAIL wrap_end got v=%b a=%h nb=%0d nh=%0d exp v=1 a=3000ff00 nb=4 nh=0",
               out_req_valid, out_req_addr, out_req_nb_dsc, out_req_new_head);
    end
    accept();
    wait_valid();
    checks++;
    if (out_req_valid !== 1'b1 || out_req_addr !== 64'h3000_0000 || out_req_nb_dsc !== 4'd4 ||
        out_req_new_head !== 11'd4) begin
      failures++;
      $display("FAIL wrap_start got v=%b a=%h nb=%0d nh=%0d exp v=1 a=30000000 nb=4 nh=4",
               out_req_valid, out_req_addr, out_req_nb_dsc, out_req_new_head);
    end
    accept();
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_q    [4];
    logic [63:0] exp_addr [4];
    logic [3:0]  got_q    [4];
    logic [63:0] got_addr [4];
    logic [3:0]  got_nb   [4];
    int got = 0;
    int n = 0;
    exp_q[0] = 4'd2; exp_addr[0] = 64'h4000_0000;
    exp_q[1] = 4'd5; exp_addr[1] = 64'h5000_0000;
    exp_q[2] = 4'd2; exp_addr[2] = 64'h4000_0200;
    exp_q[3] = 4'd5; exp_addr[3] = 64'h5000_0200;
    do_reset();
    cfg_write(4'd2, 1'b1, 64'h4000_0000);
    cfg_write(4'd5, 1'b1, 64'h5000_0000);
    tail_write(4'd2, 11'd16);
    wait_valid();
    tail_write(4'd5, 11'd16);
    out_req_ready = 1'b1;
    while (got < 4 && n < 200) begin
      if (out_req_valid) begin
        got_q[got] = out_req_queue_id; got_addr[got] = out_req_addr; got_nb[got] = out_req_nb_dsc;
        got++;
      end
      @(posedge clk); #1;
      n++;
    end
    out_req_ready = 1'b0;
    checks++;
    if (got !== 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_addr[i] !== exp_addr[i] || got_nb[i] !== 4'd8) begin
        failures++;
        $display("FAIL rr_req%0d got q=%0d a=%h nb=%0d exp q=%0d a=%h nb=8", i,
                 got_q[i], got_addr[i], got_nb[i], exp_q[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_stall();
    int unstable = 0;
    do_reset();
    cfg_write(4'd0, 1'b1, 64'h6000_0000);
    tail_write(4'd0, 11'd3);
    wait_valid();
    tail_write(4'd0, 11'd9);
    for (int i = 0; i < 10; i++) begin
      if (out_req_valid !== 1'b1 || out_req_addr !== 64'h6000_0000 || out_req_nb_dsc !== 4'd3 ||
          out_req_new_head !== 11'd3 || out_req_queue_id !== 4'd0) unstable++;
      @(posedge clk); #1;
    end
    checks++;
    if (unstable !== 0) begin failures++; $display("FAIL stall_stable got=%0d bad cycles exp=0", unstable); end
    accept();
    checks++;
    if (req_cnt !== 32'd1) begin failures++; $display("FAIL stall_req_cnt got=%0d exp=1", req_cnt); end
    wait_valid();
    checks++;
    if (out_req_valid !== 1'b1 || out_req_addr !== 64'h6000_00C0 || out_req_nb_dsc !== 4'd6 ||
        out_req_new_head !== 11'd9) begin
      failures++;
      $display("FAIL stall_second got v=%b a=%h nb=%0d nh=%0d exp v=1 a=600000c0 nb=6 nh=9",
               out_req_valid, out_req_addr, out_req_nb_dsc, out_req_new_head);
    end
    accept();
  endtask

  task automatic test_cfg_during_issue();
    int hits;
    do_reset();
    cfg_write(4'd8, 1'b1, 64'h7000_0000);
    tail_write(4'd8, 11'd4);
    wait_valid();
    cfg_write(4'd8, 1'b1, 64'h7000_0000);
    checks++;
    if (out_req_valid !== 1'b1 || out_req_nb_dsc !== 4'd4) begin
      failures++; $display("FAIL cfg_issue_hold got v=%b nb=%0d exp v=1 nb=4", out_req_valid, out_req_nb_dsc);
    end
    accept();
    count_valid(30, hits);
    checks++;
    if (hits !== 0) begin failures++; $display("FAIL cfg_issue_cleared got=%0d exp=0", hits); end
    tail_write(4'd8, 11'd2);
    wait_valid();
    checks++;
    if (out_req_valid !== 1'b1 || out_req_addr !== 64'h7000_0000 || out_req_nb_dsc !== 4'd2 ||
        out_req_new_head !== 11'd2) begin
      failures++;
      $display("FAIL cfg_issue_head got v=%b a=%h nb=%0d nh=%0d exp v=1 a=70000000 nb=2 nh=2",
               out_req_valid, out_req_addr, out_req_nb_dsc, out_req_new_head);
    end
    accept();
  endtask

  task automatic test_bad_tail();
    int hits;
    do_reset();
    cfg_write(4'd4, 1'b1, 64'h9000_0000);
    tail_write(4'd4, 11'd1024);
    count_valid(30, hits);
    checks++;
    if (hits !== 0 || bad_tail_cnt !== 32'd1) begin
      failures++; $display("FAIL bad_tail got hits=%0d cnt=%0d exp hits=0 cnt=1", hits, bad_tail_cnt);
    end
    tail_write(4'd7, 11'd10);
    count_valid(30, hits);
    checks++;
    if (hits !== 0 || bad_tail_cnt !== 32'd1) begin
      failures++; $display("FAIL disabled_q got hits=%0d cnt=%0d exp hits=0 cnt=1", hits, bad_tail_cnt);
    end
    tail_write(4'd4, 11'd1023);
    wait_valid();
    checks++;
    if (out_req_valid !== 1'b1 || out_req_queue_id !== 4'd4 || out_req_nb_dsc !== 4'd8 ||
        out_req_new_head !== 11'd8) begin
      failures++;
      $display("FAIL full_ring got v=%b q=%0d nb=%0d nh=%0d exp v=1 q=4 nb=8 nh=8",
               out_req_valid, out_req_queue_id, out_req_nb_dsc, out_req_new_head);
    end
  endtask

  task automatic test_reset_mid_issue();
    int hits;
    do_reset();
    cfg_write(4'd6, 1'b1, 64'h8000_0000);
    tail_write(4'd6, 11'd2);
    wait_valid();
    accept();
    tail_write(4'd6, 11'd2000);
    tail_write(4'd6, 11'd5);
    wait_valid();
    checks++;
    if (out_req_valid !== 1'b1 || req_cnt !== 32'd1 || bad_tail_cnt !== 32'd1) begin
      failures++;
      $display("FAIL pre_reset got v=%b req=%0d bad=%0d exp v=1 req=1 bad=1", out_req_valid, req_cnt, bad_tail_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_req_valid !== 1'b0 || req_cnt !== 32'd0 || bad_tail_cnt !== 32'd0) begin
      failures++;
      $display("FAIL async_reset got v=%b req=%0d bad=%0d exp v=0 req=0 bad=0", out_req_valid, req_cnt, bad_tail_cnt);
    end
    @(posedge clk); #1 rst = 1'b0;
    count_valid(30, hits);
    checks++;
    if (hits !== 0) begin failures++; $display("FAIL post_reset_idle got=%0d exp=0", hits); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_split();
    test_wrap();
    test_round_robin();
    test_stall();
    test_cfg_during_issue();
    test_bad_tail();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
